bit_serializer: RTL and testbench

Upstream feeder for the serial pattern detectors (e.g. the 0110 detector). It accepts parallel words over a valid/ready handshake and shifts them out one bit per enabled cycle on a single-bit line. That line connects directly to the detector's `in` input. Back-to-back words stream with no idle gap, so a pattern spanning a word boundary is still detected.

---
 rtl/seq_pkg.sv | 13 +
 rtl/bit_serializer.sv | 86 ++++++++
 tb/tb_bit_serializer.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern path: the serializer FSM encoding
// and the default word width / idle level that the detectors reuse.
package seq_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } ser_state_e;

   localparam int   DEFAULT_DATA_W   = 8;
   localparam logic DEFAULT_IDLE_BIT = 1'b1;

endpackage : seq_pkg

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder: accepts words over valid/ready and shifts them out
// one bit per enabled cycle, streaming consecutive words with no idle gap.
module bit_serializer
   import seq_pkg::*;
#(
   parameter int   DATA_W    = DEFAULT_DATA_W,
   parameter bit   MSB_FIRST = 1'b1,
   parameter logic IDLE_BIT  = DEFAULT_IDLE_BIT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid,
   output logic              data_ready,
   input  logic              bit_en,
   output logic              bit_out,
   output logic              bit_valid,
   output logic              busy,
   output logic              frame_done
);

   localparam int               CNT_W    = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

   ser_state_e        state_q, state_d;
   logic [DATA_W-1:0] sreg_q, sreg_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              last;
   logic              accept;
   logic              head;
   logic [DATA_W-1:0] shifted;

   assign last       = (cnt_q == LAST_CNT);
   assign busy       = (state_q == ST_SHIFT);
   assign bit_valid  = busy && bit_en;
   assign frame_done = bit_valid && last;
   assign data_ready = !rst && ((state_q == ST_IDLE) || (busy && last && bit_en));
   assign accept     = data_valid && data_ready;
   assign bit_out    = busy ? head : IDLE_BIT;

   always_comb begin
      head    = 1'b0;
      shifted = '0;
      if (MSB_FIRST) begin
         head    = sreg_q[DATA_W-1];
         shifted = {sreg_q[DATA_W-2:0], 1'b0};
      end else begin
         head    = sreg_q[0];
         shifted = {1'b0, sreg_q[DATA_W-1:1]};
      end
   end

   // A reload on the last-bit cycle takes priority so words chain without a gap
   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      cnt_d   = cnt_q;
      if (accept) begin
         state_d = ST_SHIFT;
         sreg_d  = data_in;
         cnt_d   = '0;
      end else if (bit_valid) begin
         if (last) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end else begin
            sreg_d = shifted;
            cnt_d  = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sreg_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule : bit_serializer

// File: tb/tb_bit_serializer.sv
// Directed self-checking bench for bit_serializer: MSB-first and LSB-first
// instances, back-to-back streaming, bit_en stretching and mid-frame reset.
module tb_bit_serializer;

   logic       clk;
   logic       rst;
   logic [7:0] data_in;
   logic       data_valid;
   logic       data_valid_lsb;
   logic       bit_en;

   logic data_ready, bit_out, bit_valid, busy, frame_done;
   logic data_ready_l, bit_out_l, bit_valid_l, busy_l, frame_done_l;

   int n_checks = 0;
   int n_fail   = 0;

   logic [4:0] obs;
   logic [4:0] exp_v;

   bit_serializer #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .bit_en     (bit_en),
      .bit_out    (bit_out),
      .bit_valid  (bit_valid),
      .busy       (busy),
      .frame_done (frame_done)
   );

   bit_serializer #(.DATA_W(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_lsb (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .data_valid (data_valid_lsb),
      .data_ready (data_ready_l),
      .bit_en     (bit_en),
      .bit_out    (bit_out_l),
      .bit_valid  (bit_valid_l),
      .busy       (busy_l),
      .frame_done (frame_done_l)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge so inputs change away from it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; data_valid = 1'b1; data_in = 8'hFF; bit_en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         #1;
         obs   = {bit_out, bit_valid, frame_done, busy, data_ready};
         exp_v = 5'b1_0_0_0_0;
         n_checks++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL reset_hold cyc%0d: got %b want %b", k, obs, exp_v);
         end
      end
      data_valid = 1'b0;
      tick();
      rst = 1'b0;
      #1;
      obs   = {bit_out, bit_valid, frame_done, busy, data_ready};
      exp_v = 5'b1_0_0_0_1;
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("[TB] FAIL reset_release: got %b want %b", obs, exp_v);
      end
   endtask

   task automatic test_single_word();
      logic [7:0] w;
      w = 8'h36;
      data_in = w; data_valid = 1'b1; bit_en = 1'b1;
      #1;
      n_checks++;
      if (data_ready !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL single_ready: got %b want 1", data_ready);
      end
      for (int i = 0; i < 8; i++) begin
         tick();
         data_valid = 1'b0;
         #1;
         obs   = {bit_out, bit_valid, frame_done, busy, data_ready};
         exp_v = {w[7-i], 1'b1, (i == 7), 1'b1, (i == 7)};
         n_checks++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL single_bit%0d: got %b want %b", i, obs, exp_v);
         end
      end
      tick();
      #1;
      obs   = {bit_out, bit_valid, frame_done, busy, data_ready};
      exp_v = 5'b1_0_0_0_1;
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("[TB] FAIL single_after: got %b want %b", obs, exp_v);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] stream;
      stream = 16'hA53C;
      data_in = 8'hA5; data_valid = 1'b1; bit_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (i == 0) data_in = 8'h3C;
         if (i == 8) data_valid = 1'b0;
         #1;
         obs   = {bit_out, bit_valid, frame_done, busy, data_ready};
         exp_v = {stream[15-i], 1'b1, (i % 8 == 7), 1'b1, (i % 8 == 7)};
         n_checks++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL b2b_bit%0d: got %b want %b", i, obs, exp_v);
         end
      end
      tick();
      #1;
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL b2b_end_busy: got %b want 0", busy);
      end
   endtask

   task automatic test_bit_en_stretch();
      logic [7:0] w;
      w = 8'h0F;
      data_in = w; data_valid = 1'b1; bit_en = 1'b1;
      for (int k = 0; k < 16; k++) begin
         tick();
         data_valid = 1'b0;
         bit_en = (k % 2 == 1);
         #1;
         obs   = {bit_out, bit_valid, frame_done, busy, data_ready};
         exp_v = {w[7-(k/2)], (k % 2 == 1), (k == 15), 1'b1, (k == 15)};
         n_checks++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL stretch_cyc%0d: got %b want %b", k, obs, exp_v);
         end
      end
      bit_en = 1'b1;
      tick();
      #1;
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL stretch_end_busy: got %b want 0", busy);
      end
   endtask

   task automatic test_lsb_first();
      logic [7:0] exp_bits;
      exp_bits = 8'b0110_0000;
      data_in = 8'h06; data_valid_lsb = 1'b1; bit_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         data_valid_lsb = 1'b0;
         #1;
         obs   = {bit_out_l, bit_valid_l, frame_done_l, busy_l, data_ready_l};
         exp_v = {exp_bits[7-i], 1'b1, (i == 7), 1'b1, (i == 7)};
         n_checks++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL lsb_bit%0d: got %b want %b", i, obs, exp_v);
         end
      end
      tick();
      #1;
      n_checks++;
      if ({busy_l, busy} !== 2'b00) begin
         n_fail++;
         $display("[TB] FAIL lsb_end_busy: got %b want 00", {busy_l, busy});
      end
   endtask

   task automatic test_mid_frame_reset();
      logic [7:0] w;
      data_in = 8'hFF; data_valid = 1'b1; bit_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         data_valid = 1'b0;
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (data_ready !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL rst_ready_low: got %b want 0", data_ready);
      end
      tick();
      rst = 1'b0;
      w = 8'h81;
      data_in = w; data_valid = 1'b1;
      #1;
      obs   = {bit_out, bit_valid, frame_done, busy, data_ready};
      exp_v = 5'b1_0_0_0_1;
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("[TB] FAIL rst_abort: got %b want %b", obs, exp_v);
      end
      for (int i = 0; i < 8; i++) begin
         tick();
         data_valid = 1'b0;
         #1;
         obs   = {bit_out, bit_valid, frame_done, busy, data_ready};
         exp_v = {w[7-i], 1'b1, (i == 7), 1'b1, (i == 7)};
         n_checks++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL rst_fresh_bit%0d: got %b want %b", i, obs, exp_v);
         end
      end
      tick();
   endtask

   task automatic test_pending_word();
      logic [15:0] stream;
      stream = 16'hC322;
      data_in = 8'hC3; data_valid = 1'b1; bit_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (i == 0) data_in = 8'h11;
         if (i == 4) data_in = 8'h22;
         if (i == 8) begin
            data_valid = 1'b0;
            data_in = 8'h11;
         end
         #1;
         obs   = {bit_out, bit_valid, frame_done, busy, data_ready};
         exp_v = {stream[15-i], 1'b1, (i % 8 == 7), 1'b1, (i % 8 == 7)};
         n_checks++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL pending_bit%0d: got %b want %b", i, obs, exp_v);
         end
      end
      for (int k = 0; k < 2; k++) begin
         tick();
         #1;
         obs   = {bit_out, bit_valid, frame_done, busy, data_ready};
         exp_v = 5'b1_0_0_0_1;
         n_checks++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL pending_no_dup%0d: got %b want %b", k, obs, exp_v);
         end
      end
   endtask

   initial begin
      rst = 1'b1; data_in = '0; data_valid = 1'b0; data_valid_lsb = 1'b0; bit_en = 1'b1;
      test_reset();
      test_single_word();
      test_back_to_back();
      test_bit_en_stretch();
      test_lsb_first();
      test_mid_frame_reset();
      test_pending_word();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_bit_serializer
